// File: rtl/wb_dest_tracker.sv
// Destination-register decode, issue-to-writeback delay line and per-register
// pending-write scoreboard with RAW hazard detection on source operands.
module wb_dest_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int STAGES     = 3,
    parameter int LINK_REG   = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     reg_write,
    input  logic [1:0]               reg_dst,
    input  logic [REG_ADDR_W-1:0]    rt,
    input  logic [REG_ADDR_W-1:0]    rd,
    input  logic [REG_ADDR_W-1:0]    src_a,
    input  logic [REG_ADDR_W-1:0]    src_b,
    input  logic                     stall,
    input  logic                     flush,
    output logic                     hazard,
    output logic                     wb_valid,
    output logic                     wb_en,
    output logic [REG_ADDR_W-1:0]    wb_reg,
    output logic [2**REG_ADDR_W-1:0] busy_mask
);

    localparam int NREGS = 2**REG_ADDR_W;
    localparam int CW    = $clog2(STAGES + 1);

    typedef struct packed {
        logic                  vld;
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
    } slot_t;

    slot_t           stage_q [STAGES];
    slot_t           stage_d [STAGES];
    logic [CW-1:0]   cnt_q   [NREGS];
    logic [CW-1:0]   cnt_d   [NREGS];
    logic [NREGS-1:0] inc_v;
    logic [NREGS-1:0] dec_v;

    logic [REG_ADDR_W-1:0] dest;
    logic                  dest_en;
    logic                  accept;

    always_comb begin
        dest = '0;
        case (reg_dst)
            2'b00:   dest = rt;
            2'b01:   dest = rd;
            2'b10:   dest = REG_ADDR_W'(LINK_REG);
            default: dest = '0;
        endcase
    end

    assign dest_en = reg_write && (reg_dst != 2'b11) && (dest != '0);

    // Registered counts only: a write retiring this cycle still blocks the reader.
    assign hazard = issue_valid &&
                    (((src_a != '0) && busy_mask[src_a]) ||
                     ((src_b != '0) && busy_mask[src_b]));

    assign accept   = issue_valid && !hazard && !stall && !flush;
    assign wb_valid = stage_q[STAGES-1].vld && !stall;
    assign wb_en    = wb_valid && stage_q[STAGES-1].en;
    assign wb_reg   = stage_q[STAGES-1].addr;

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_d[i].vld = 1'b0;
                stage_d[i].en  = 1'b0;
            end
        end else if (!stall) begin
            stage_d[0] = accept ? '{vld: 1'b1, en: dest_en, addr: dest} : '0;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stall needs no explicit hold here: accept and wb_en are both low while stalled.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            inc_v[i] = accept && dest_en && (dest == REG_ADDR_W'(i));
            dec_v[i] = wb_en && (wb_reg == REG_ADDR_W'(i));
            cnt_d[i] = flush ? '0 : cnt_q[i] + CW'(inc_v[i]) - CW'(dec_v[i]);
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            busy_mask[i] = (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt_q[i] <= cnt_d[i];
                assert (flush || !(inc_v[i] && !dec_v[i] && (cnt_q[i] == '1)));
                assert (flush || !(dec_v[i] && !inc_v[i] && (cnt_q[i] == '0)));
            end
        end
    end

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Randomized bench: an in-flight list model predicts hazards, busy registers and
// the ordered write-back stream; a monitor pops expected retirements as they appear.
module tb_wb_dest_tracker;

    localparam int AW = 5;
    localparam int ST = 3;
    localparam int NR = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, reg_write, stall, flush;
    logic [1:0]    reg_dst;
    logic [AW-1:0] rt, rd, src_a, src_b;
    logic          hazard, wb_valid, wb_en;
    logic [AW-1:0] wb_reg;
    logic [NR-1:0] busy_mask;

    always #5 clk = ~clk;

    wb_dest_tracker #(.REG_ADDR_W(AW), .STAGES(ST), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .reg_write(reg_write),
        .reg_dst(reg_dst), .rt(rt), .rd(rd), .src_a(src_a), .src_b(src_b),
        .stall(stall), .flush(flush), .hazard(hazard), .wb_valid(wb_valid),
        .wb_en(wb_en), .wb_reg(wb_reg), .busy_mask(busy_mask)
    );

    typedef struct { bit en; bit [AW-1:0] r; int rem; } ent_t;
    typedef struct { bit en; bit [AW-1:0] r; bit chk_reg; } exp_t;

    ent_t fl[$];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input bit [AW-1:0] a);
        foreach (fl[k]) if (fl[k].en && fl[k].r == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd9;
            3: return 5'd31;
            default: return AW'($urandom_range(0, NR-1));
        endcase
    endfunction

    // One clock cycle with the currently driven inputs: compare, then advance the model.
    task automatic cycle();
        logic [NR-1:0] eb;
        bit            eh, pres, acc, den;
        bit [AW-1:0]   d;
        @(negedge clk);
        eb = '0;
        for (int i = 1; i < NR; i++) eb[i] = m_busy(AW'(i));
        eh   = issue_valid && ((src_a != 0 && eb[src_a]) || (src_b != 0 && eb[src_b]));
        pres = !stall && fl.size() > 0 && fl[0].rem == 0;
        chk("hazard", hazard, eh);
        chk("busy_mask", busy_mask, eb);
        chk("wb_valid", wb_valid, pres);
        #1;
        d   = (reg_dst == 2'b00) ? rt : (reg_dst == 2'b01) ? rd : 5'd31;
        den = reg_write && reg_dst != 2'b11 && d != 0;
        acc = issue_valid && !eh && !stall && !flush;
        if (flush) begin
            fl.delete();
            exp_q.delete();
        end else if (!stall) begin
            if (pres) void'(fl.pop_front());
            foreach (fl[k]) if (fl[k].rem > 0) fl[k].rem--;
            if (acc) begin
                fl.push_back('{en: den, r: d, rem: ST-1});
                exp_q.push_back('{en: den, r: d, chk_reg: reg_dst != 2'b11});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got wb_reg %0d wb_en %0b expected no write-back", wb_reg, wb_en);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_en", wb_en, e.en);
                    if (e.chk_reg) chk("wb_reg", wb_reg, e.r);
                end
            end
        end
    end

    initial begin : stim
        int stall_left = 0;
        rst = 1'b1; issue_valid = 1'b1; reg_write = 1'b1; reg_dst = 2'b01;
        rt = 5'd5; rd = 5'd9; src_a = 5'd5; src_b = 5'd9; stall = 1'b0; flush = 1'b0;
        #2;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_reg", wb_reg, '0);
        chk("rst_busy", busy_mask, '0);
        chk("rst_hazard", hazard, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        for (int c = 0; c < 2000; c++) begin
            issue_valid = $urandom_range(0, 3) != 0;
            reg_write   = $urandom_range(0, 4) != 0;
            reg_dst     = 2'($urandom_range(0, 3));
            rt = pick(); rd = pick(); src_a = pick(); src_b = pick();
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                stall = 1'b1;
                stall_left = $urandom_range(0, 4);
            end else begin
                stall = 1'b0;
            end
            flush = $urandom_range(0, 32) == 0;
            if (c == 1000) begin
                #1 rst = 1'b1;
                #1;
                chk("midrst_wb_valid", wb_valid, 1'b0);
                chk("midrst_busy", busy_mask, '0);
                chk("midrst_hazard", hazard, 1'b0);
                fl.delete();
                exp_q.delete();
                rst = 1'b0;
            end
            cycle();
        end

        issue_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int c = 0; c < ST + 3; c++) cycle();
        chk("drain_model", fl.size(), 0);
        chk("drain_expq", exp_q.size(), 0);
        chk("drain_busy", busy_mask, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
